multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control unit for the npc RV64 core: fetches one instruction at a time over a req/ack memory handshake, decodes it into the core's datapath control signals, sequences it through FETCH/DECODE/EXEC/MEM/WB and resolves branches internally. It sits between the instruction/data memory interfaces, the register file read ports and the PC/ALU/writeback muxes, and makes memory latency variable without changing the datapath.

## Interface
- XLEN, 64: width of reg1/reg2 and of the branch comparator.
- RESET_INST, 32'h00000013: reset value of the internal instruction register (NOP).
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- reg1, reg2  in  XLEN  register file read data for rs1/rs2.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1.
- dmem_ack  in  1  data access complete.
- ir  out  32  latched instruction.
- alu_src, mem2reg, spc2reg, need_sext, pc2imm  out  1 each  datapath selects; encoding is the core's existing encoding.
- alu_op  out  2  ALU op class.
- has_funct  out  2  funct field usage.
- funct3  out  3  ir[14:12].
- reg_w  out  1  register write strobe, one cycle.
- pc_we  out  1  PC update strobe, one cycle.
- pc_sel  out  2  00 pc+4, 01 pc+imm, 10 ALU result (jalr), 11 unused.
- retire  out  1  one-cycle pulse per completed instruction.
- busy  out  1  1 in every state except FETCH.
- trap  out  1  illegal instruction (see Configuration).

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: imem_req=1 until imem_ack; on ack, ir<=imem_rdata, go DECODE.
- DECODE: decode ir[6:0] into control registers (load 0000011, store 0100011, OP-IMM 0010011, OP 0110011, AUIPC 0010111, JAL 1101111, JALR 1100111, LUI 0110111, OPW 0111011, OP-IMMW 0011011, BRANCH 1100011). Controls held constant until the next DECODE. Go EXEC.
- EXEC: branch: evaluate condition on reg1/reg2 (XLEN wide; funct3 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 not taken); pc_we=1, pc_sel=01 if taken else 00, retire=1, go FETCH. Load/store: go MEM. All other legal opcodes: go WB.
- MEM: dmem_req=1, dmem_we=1 for store; hold until dmem_ack. On ack: store → pc_we=1, pc_sel=00, retire=1, go FETCH; load → go WB.
- WB: reg_w=1, pc_we=1, retire=1; pc_sel=01 for JAL, 10 for JALR, else 00; go FETCH.
- Outputs are Moore functions of state and control registers; strobes (reg_w, pc_we, retire) are high exactly one cycle.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.

## Timing
- Reset (rst=1 at an edge): state=FETCH, ir=RESET_INST, all control registers 0. Following cycle: imem_req=1, every other output 0, trap=0.
- Reset in any state, including mid-MEM or TRAP: takes effect at the next edge; dmem_req falls; a late ack is ignored.
- Zero-wait memory (ack in same cycle as req): branch 3 cycles, ALU/LUI/AUIPC/JAL/JALR and store 4 cycles, load 5 cycles, FETCH-to-FETCH. Each wait cycle on ack adds one cycle.
- Branch comparison samples reg1/reg2 in EXEC; the register file must be stable from DECODE onward.
- Simultaneous ack and rst: rst wins; ir is not updated.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: an unlisted opcode in DECODE moves to TRAP; trap=1, busy=1, no pc_we/retire; TRAP held until rst.
- Undefined: unlisted opcode executes as a NOP: DECODE → EXEC, then pc_we=1, pc_sel=00, retire=1 in EXEC, back to FETCH; trap tied 0.

## Test plan
- Reset then addi (0x00100093), zero-wait memory → imem_req at cycle 1, reg_w and retire pulse in cycle 4, pc_sel=00.
- beq with reg1=reg2=64'h5 → EXEC pc_we=1, pc_sel=01, retire; bltu with reg1=64'hFFFF_FFFF_FFFF_FFFF, reg2=1 → not taken, pc_sel=00; blt same values → taken.
- ld with dmem_ack delayed 3 cycles → dmem_req high 4 cycles, dmem_we=0, mem2reg=1, reg_w 1 cycle after ack; 8 cycles total.
- sd with zero-wait → dmem_we=1, retire with ack in MEM, reg_w never asserted.
- rst asserted during MEM wait, dmem_ack arriving 1 cycle later → FETCH state, no reg_w/retire, imem_req=1.
- Opcode 7'b1111111: with CTRL_ILLEGAL_TRAP_EN → trap=1 from cycle 3, held until rst; without → retire in EXEC, pc_sel=00, trap=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit for the npc RV64 core.
// Define CTRL_ILLEGAL_TRAP_EN to trap on unlisted opcodes; otherwise they retire as NOPs.
module multicycle_ctrl #(
    parameter int          XLEN       = 64,
    parameter logic [31:0] RESET_INST = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] reg2,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic [31:0]     ir,
    output logic            alu_src,
    output logic            mem2reg,
    output logic            spc2reg,
    output logic            need_sext,
    output logic            pc2imm,
    output logic [1:0]      alu_op,
    output logic [1:0]      has_funct,
    output logic [2:0]      funct3,
    output logic            reg_w,
    output logic            pc_we,
    output logic [1:0]      pc_sel,
    output logic            retire,
    output logic            busy,
    output logic            trap
);

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_OPW     = 7'b0111011;
    localparam logic [6:0] OPC_OPIMMW  = 7'b0011011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

    typedef struct packed {
        logic       alu_src;
        logic       mem2reg;
        logic       spc2reg;
        logic       need_sext;
        logic       pc2imm;
        logic [1:0] alu_op;
        logic [1:0] has_funct;
        logic       is_branch;
        logic       is_load;
        logic       is_store;
        logic       is_jal;
        logic       is_jalr;
        logic       is_nop;
    } ctrl_t;

    state_t     state;
    ctrl_t      ctrl;
    ctrl_t      dec;
    logic       dec_illegal;
    logic       pc_we_r;
    logic       retire_r;
    logic [1:0] pc_sel_r;
    logic       trap_r;
    logic       store_done;

    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        sa = a;
        sb = b;
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        case (ir[6:0])
            OPC_LOAD:   begin dec.alu_src = 1'b1; dec.mem2reg = 1'b1; dec.is_load = 1'b1; end
            OPC_STORE:  begin dec.alu_src = 1'b1; dec.is_store = 1'b1; end
            OPC_OPIMM:  begin dec.alu_src = 1'b1; dec.alu_op = 2'b10; dec.has_funct = 2'b01; end
            OPC_OP:     begin dec.alu_op = 2'b10; dec.has_funct = 2'b11; end
            OPC_AUIPC:  begin dec.alu_src = 1'b1; dec.pc2imm = 1'b1; end
            OPC_JAL:    begin dec.spc2reg = 1'b1; dec.is_jal = 1'b1; end
            OPC_JALR:   begin dec.alu_src = 1'b1; dec.spc2reg = 1'b1; dec.is_jalr = 1'b1; end
            OPC_LUI:    begin dec.alu_src = 1'b1; dec.alu_op = 2'b11; end
            OPC_OPW:    begin dec.alu_op = 2'b10; dec.has_funct = 2'b11; dec.need_sext = 1'b1; end
            OPC_OPIMMW: begin
                dec.alu_src   = 1'b1;
                dec.alu_op    = 2'b10;
                dec.has_funct = 2'b01;
                dec.need_sext = 1'b1;
            end
            OPC_BRANCH: begin dec.alu_op = 2'b01; dec.is_branch = 1'b1; end
            default:    begin dec_illegal = 1'b1; dec.is_nop = 1'b1; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            ir       <= RESET_INST;
            ctrl     <= '0;
            imem_req <= 1'b1;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            reg_w    <= 1'b0;
            pc_we_r  <= 1'b0;
            retire_r <= 1'b0;
            pc_sel_r <= 2'b00;
            busy     <= 1'b0;
            trap_r   <= 1'b0;
        end else begin
            reg_w    <= 1'b0;
            pc_we_r  <= 1'b0;
            retire_r <= 1'b0;
            pc_sel_r <= 2'b00;
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        busy     <= 1'b1;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    ctrl <= dec;
                    if (dec_illegal && TRAP_EN) begin
                        trap_r <= 1'b1;
                        state  <= TRAP;
                    end else begin
                        state <= EXEC;
                        // Branches and NOPs complete in EXEC, so their strobes are armed here.
                        if (dec.is_branch || dec.is_nop) begin
                            pc_we_r  <= 1'b1;
                            retire_r <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (ctrl.is_load || ctrl.is_store) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= ctrl.is_store;
                        state    <= MEM;
                    end else if (ctrl.is_branch || ctrl.is_nop) begin
                        imem_req <= 1'b1;
                        busy     <= 1'b0;
                        state    <= FETCH;
                    end else begin
                        reg_w    <= 1'b1;
                        pc_we_r  <= 1'b1;
                        retire_r <= 1'b1;
                        pc_sel_r <= ctrl.is_jal ? 2'b01 : (ctrl.is_jalr ? 2'b10 : 2'b00);
                        state    <= WB;
                    end
                end
                MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (ctrl.is_store) begin
                            imem_req <= 1'b1;
                            busy     <= 1'b0;
                            state    <= FETCH;
                        end else begin
                            reg_w    <= 1'b1;
                            pc_we_r  <= 1'b1;
                            retire_r <= 1'b1;
                            state    <= WB;
                        end
                    end
                end
                WB: begin
                    imem_req <= 1'b1;
                    busy     <= 1'b0;
                    state    <= FETCH;
                end
                TRAP: state <= TRAP;
                default: begin
                    imem_req <= 1'b1;
                    busy     <= 1'b0;
                    state    <= FETCH;
                end
            endcase
        end
    end

    // A store retires in the very cycle its ack arrives, which keeps zero-wait stores at 4 cycles.
    assign store_done = (state == MEM) && ctrl.is_store && dmem_ack && !rst;
    assign pc_we      = pc_we_r | store_done;
    assign retire     = retire_r | store_done;
    assign pc_sel     = (state == EXEC && ctrl.is_branch) ?
                        {1'b0, branch_taken(ir[14:12], reg1, reg2)} : pc_sel_r;

    assign alu_src   = ctrl.alu_src;
    assign mem2reg   = ctrl.mem2reg;
    assign spc2reg   = ctrl.spc2reg;
    assign need_sext = ctrl.need_sext;
    assign pc2imm    = ctrl.pc2imm;
    assign alu_op    = ctrl.alu_op;
    assign has_funct = ctrl.has_funct;
    assign funct3    = ir[14:12];
    assign trap      = trap_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases then random instruction streams
// compared cycle by cycle against a phase-duration model of each instruction class.
module tb_multicycle_ctrl;
    localparam int XLEN = 64;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam int C_ALU = 0, C_BR = 1, C_LD = 2, C_ST = 3, C_ILL = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            imem_req, imem_ack = 1'b0;
    logic [31:0]     imem_rdata = '0;
    logic [XLEN-1:0] reg1 = '0, reg2 = '0;
    logic            dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [31:0]     ir;
    logic            alu_src, mem2reg, spc2reg, need_sext, pc2imm;
    logic [1:0]      alu_op, has_funct, pc_sel;
    logic [2:0]      funct3;
    logic            reg_w, pc_we, retire, busy, trap;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_ctrl #(.XLEN(XLEN), .RESET_INST(32'h00000013)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .reg1(reg1), .reg2(reg2), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_ack(dmem_ack), .ir(ir), .alu_src(alu_src),
        .mem2reg(mem2reg), .spc2reg(spc2reg), .need_sext(need_sext), .pc2imm(pc2imm),
        .alu_op(alu_op), .has_funct(has_funct), .funct3(funct3), .reg_w(reg_w),
        .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire), .busy(busy), .trap(trap)
    );

    always #5 clk = ~clk;

    logic [9:0] obs;
    assign obs = {imem_req, dmem_req, dmem_we, reg_w, pc_we, pc_sel, retire, busy, trap};

    function automatic logic [9:0] mk(bit ireq, bit dreq, bit we, bit rw, bit pw,
                                      logic [1:0] ps, bit ret, bit bz, bit tr);
        return {ireq, dreq, we, rw, pw, ps, ret, bz, tr};
    endfunction

    task automatic check_vec(string tag, logic [9:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed ireq,dreq,we,rw,pw,psel,ret,busy,trap=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check64(string tag, logic [63:0] o, logic [63:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    function automatic int classify(logic [6:0] opc);
        case (opc)
            7'b1100011: return C_BR;
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            7'b0010011, 7'b0110011, 7'b0010111, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0111011, 7'b0011011: return C_ALU;
            default: return C_ILL;
        endcase
    endfunction

    function automatic bit br_model(logic [2:0] f3, logic [63:0] a, logic [63:0] b);
        longint sa = a;
        longint sb = b;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Enters at a negedge with rst low; leaves in the first FETCH cycle after reset.
    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_vec("reset_outputs", mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        check64("reset_ir", 64'(ir), 64'h13);
        check64("reset_ctrl", 64'({alu_src, mem2reg, spc2reg, need_sext, pc2imm, alu_op, has_funct}), 64'h0);
    endtask

    // Runs one instruction starting in FETCH. iw/dw are ack wait cycles; rst_mem>=0 resets
    // in that MEM cycle and then delivers the late dmem_ack.
    task automatic run_instr(input logic [31:0] inst, input logic [63:0] r1, input logic [63:0] r2,
                             input int iw, input int dw, input int rst_mem);
        logic [9:0] eq[$];
        int         ph[$];
        bit         ak[$];
        int         cls, mi;
        bit         st, taken;
        logic [1:0] wsel;
        cls   = classify(inst[6:0]);
        st    = (cls == C_ST);
        taken = (cls == C_BR) && br_model(inst[14:12], r1, r2);
        wsel  = (inst[6:0] == 7'b1101111) ? 2'b01 : ((inst[6:0] == 7'b1100111) ? 2'b10 : 2'b00);
        for (int k = 0; k <= iw; k++) begin
            eq.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0)); ph.push_back(1); ak.push_back(k == iw);
        end
        eq.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 1, 0)); ph.push_back(0); ak.push_back(0);
        if (cls == C_ILL && TRAP_EN) begin
            for (int k = 0; k < 3; k++) begin
                eq.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 1, 1)); ph.push_back(0); ak.push_back(0);
            end
        end else if (cls == C_BR || cls == C_ILL) begin
            eq.push_back(mk(0, 0, 0, 0, 1, {1'b0, taken}, 1, 1, 0)); ph.push_back(0); ak.push_back(0);
        end else begin
            eq.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 1, 0)); ph.push_back(0); ak.push_back(0);
            if (cls == C_LD || cls == C_ST) begin
                for (int k = 0; k <= dw; k++) begin
                    eq.push_back(mk(0, 1, st, 0, st && k == dw, 2'b00, st && k == dw, 1, 0));
                    ph.push_back(2); ak.push_back(k == dw);
                end
            end
            if (!st) begin
                eq.push_back(mk(0, 0, 0, 1, 1, (cls == C_ALU) ? wsel : 2'b00, 1, 1, 0));
                ph.push_back(0); ak.push_back(0);
            end
        end
        mi = 0;
        for (int c = 0; c < eq.size(); c++) begin
            reg1 = r1; reg2 = r2;
            if (ph[c] == 1) begin
                imem_ack = ak[c]; imem_rdata = ak[c] ? inst : $urandom;
            end else begin
                imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
            end
            dmem_ack = (ph[c] == 2) ? ak[c] : 1'($urandom_range(0, 1));
            if (ph[c] == 2 && mi == rst_mem) begin
                rst = 1'b1; dmem_ack = 1'b0; imem_ack = 1'b0;
                @(negedge clk);
                rst = 1'b0; dmem_ack = 1'b1;
                #1;
                check_vec("rst_mid_mem", mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0));
                @(negedge clk);
                #1;
                check_vec("late_ack_ignored", mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0));
                dmem_ack = 1'b0;
                return;
            end
            if (ph[c] == 2) mi++;
            #1;
            check_vec($sformatf("op%02h_cyc%0d", inst[6:0], c), eq[c]);
            if (c == iw + 1) begin
                check64("ir_latched", 64'(ir), 64'(inst));
                check64("funct3", 64'(funct3), 64'(inst[14:12]));
            end
            if (c == iw + 2 && !(cls == C_ILL && TRAP_EN))
                check64("mem2reg", 64'(mem2reg), 64'(cls == C_LD));
            @(negedge clk);
        end
        if (cls == C_ILL && TRAP_EN) do_reset();
    endtask

    logic [6:0] opcs [12] = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0010111,
                              7'b1101111, 7'b1100111, 7'b0110111, 7'b0111011, 7'b0011011,
                              7'b1100011, 7'b1111111};

    initial begin
        logic [31:0] inst;
        logic [63:0] a, b;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_reset();
        run_instr(32'h00100093, 64'h0, 64'h0, 0, 0, -1);                          // addi
        run_instr(32'h00000063, 64'h5, 64'h5, 0, 0, -1);                          // beq taken
        run_instr(32'h00006063, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, -1);        // bltu not taken
        run_instr(32'h00004063, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, -1);        // blt taken
        run_instr(32'h00003003, 64'h0, 64'h0, 0, 3, -1);                          // ld, ack late
        run_instr(32'h00003023, 64'h0, 64'h0, 0, 0, -1);                          // sd
        run_instr(32'h0000006F, 64'h0, 64'h0, 1, 0, -1);                          // jal
        run_instr(32'h00000067, 64'h0, 64'h0, 2, 0, -1);                          // jalr
        run_instr(32'h00003003, 64'h0, 64'h0, 0, 5, 2);                           // reset mid-MEM
        run_instr(32'h0000007F, 64'h0, 64'h0, 0, 0, -1);                          // illegal
        // Fetch ack coinciding with reset must not load ir.
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h00500113;
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0;
        #1;
        check64("ack_vs_rst_ir", 64'(ir), 64'h13);
        check_vec("ack_vs_rst_state", mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        for (int n = 0; n < 80; n++) begin
            inst = {$urandom} & 32'hFFFF_FF80;
            inst[6:0] = opcs[$urandom_range(0, 11)];
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ 64'h8000_0000_0000_0000;
                default: b = {$urandom, $urandom};
            endcase
            run_instr(inst, a, b, $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
